// File: rtl/div_issue_queue.sv
// div_issue_queue
// ---------------
// Age-ordered issue queue feeding one multi-cycle signed 32-bit divider.
// Entries wait for their operands by snooping the CDB (cdbin_*). The oldest
// entry with both operands ready moves into the divider. The result is then
// offered to the CDB arbiter until it is granted.
//
// Parameters: DEPTH (2..16) queue entries, LATENCY (2..34) divider busy
//             cycles, TAG_W tag width.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     (only with DIV_ISSUE_QUEUE_FLUSH_EN) drop all
//   dispatch_*                new instruction; accepted when dispatch_ready=1
//   dispatch_ready            fewer than DEPTH entries held
//   cdbin_data/tag/valid      snooped CDB broadcast (wakeup)
//   cdb_data/tag/valid        result request to the arbiter
//   cdb_grant                 arbiter accepts the presented result
//   cdb_branch(_taken)        tied to 0
//   o_dbg_state               divider state: 0=IDLE, 1=BUSY, 2=DONE
// Handshakes: a dispatch transfers on a clock edge where dispatch_en=1 and
//   dispatch_ready=1. A result transfers on a clock edge where cdb_valid=1
//   and cdb_grant=1. cdb_valid, cdb_data and cdb_tag stay stable until that
//   edge.
// Optional feature: define DIV_ISSUE_QUEUE_FLUSH_EN to add the flush port.
module div_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 8,
  parameter int TAG_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DIV_ISSUE_QUEUE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             dispatch_en,
  input  logic [TAG_W-1:0] dispatch_rdtag,
  input  logic [31:0]      dispatch_rsdata,
  input  logic [31:0]      dispatch_rtdata,
  input  logic [TAG_W-1:0] dispatch_rstag,
  input  logic [TAG_W-1:0] dispatch_rttag,
  input  logic             dispatch_rsvalid,
  input  logic             dispatch_rtvalid,
  output logic             dispatch_ready,
  input  logic [31:0]      cdbin_data,
  input  logic [TAG_W-1:0] cdbin_tag,
  input  logic             cdbin_valid,
  output logic [31:0]      cdb_data,
  output logic [TAG_W-1:0] cdb_tag,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic             cdb_branch,
  output logic             cdb_branch_taken,
  output logic [1:0]       o_dbg_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAT_W = $clog2(LATENCY + 1);

  typedef struct packed {
    logic [TAG_W-1:0] rdtag;
    logic [31:0]      rs;
    logic [31:0]      rt;
    logic [TAG_W-1:0] rstag;
    logic [TAG_W-1:0] rttag;
    logic             rsv;
    logic             rtv;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  entry_t           r_q [DEPTH];
  logic [CNT_W-1:0] r_count;
  state_t           r_state;
  logic [LAT_W-1:0] r_cnt;
  logic [31:0]      r_cdb_data;
  logic [TAG_W-1:0] r_cdb_tag;
  logic             r_cdb_valid;

  entry_t           w_wk   [DEPTH];
  entry_t           w_next [DEPTH];
  entry_t           w_new;
  entry_t           w_sel;
  logic             w_found;
  logic [IDX_W-1:0] w_issue_idx;
  logic             w_issue;
  logic             w_disp;
  logic             w_flush;
  logic [CNT_W-1:0] w_cnt_after;
  logic [CNT_W-1:0] w_next_count;
  logic [31:0]      w_quot;

`ifdef DIV_ISSUE_QUEUE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign dispatch_ready   = (r_count < CNT_W'(DEPTH));
  assign cdb_data         = r_cdb_data;
  assign cdb_tag          = r_cdb_tag;
  assign cdb_valid        = r_cdb_valid;
  assign cdb_branch       = 1'b0;
  assign cdb_branch_taken = 1'b0;
  assign o_dbg_state      = r_state;

  always_comb begin
    // Issue selection uses registered ready bits, so an entry dispatched or
    // woken this cycle can only issue from the next cycle onwards.
    w_found     = 1'b0;
    w_issue_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < r_count) && r_q[i].rsv && r_q[i].rtv) begin
        w_found     = 1'b1;
        w_issue_idx = IDX_W'(i);
      end
    end
    // Leaving DONE on a grant frees the divider in the same cycle.
    w_issue = w_found && ((r_state == S_IDLE) || ((r_state == S_DONE) && cdb_grant));
    w_sel   = r_q[w_issue_idx];

    // rt=0 and the single overflowing case are defined explicitly.
    if (w_sel.rt == 32'd0)
      w_quot = 32'hFFFF_FFFF;
    else if ((w_sel.rs == 32'h8000_0000) && (w_sel.rt == 32'hFFFF_FFFF))
      w_quot = 32'h8000_0000;
    else
      w_quot = 32'($signed(w_sel.rs) / $signed(w_sel.rt));

    for (int i = 0; i < DEPTH; i++) begin
      w_wk[i] = r_q[i];
      if (cdbin_valid && !r_q[i].rsv && (r_q[i].rstag == cdbin_tag)) begin
        w_wk[i].rsv = 1'b1;
        w_wk[i].rs  = cdbin_data;
      end
      if (cdbin_valid && !r_q[i].rtv && (r_q[i].rttag == cdbin_tag)) begin
        w_wk[i].rtv = 1'b1;
        w_wk[i].rt  = cdbin_data;
      end
    end

    // Incoming entry, including the same-cycle broadcast bypass.
    w_new.rdtag = dispatch_rdtag;
    w_new.rs    = dispatch_rsdata;
    w_new.rt    = dispatch_rtdata;
    w_new.rstag = dispatch_rstag;
    w_new.rttag = dispatch_rttag;
    w_new.rsv   = dispatch_rsvalid;
    w_new.rtv   = dispatch_rtvalid;
    if (cdbin_valid && !dispatch_rsvalid && (dispatch_rstag == cdbin_tag)) begin
      w_new.rsv = 1'b1;
      w_new.rs  = cdbin_data;
    end
    if (cdbin_valid && !dispatch_rtvalid && (dispatch_rttag == cdbin_tag)) begin
      w_new.rtv = 1'b1;
      w_new.rt  = cdbin_data;
    end

    w_disp       = dispatch_en && dispatch_ready;
    w_cnt_after  = r_count - CNT_W'(w_issue);
    w_next_count = w_cnt_after + CNT_W'(w_disp);

    // Compact younger entries over the issued slot, then append the dispatch
    // at the first free index.
    for (int i = 0; i < DEPTH; i++) begin
      w_next[i] = w_wk[i];
      if (w_issue && (IDX_W'(i) >= w_issue_idx) && (i < DEPTH - 1))
        w_next[i] = w_wk[(i < DEPTH - 1) ? i + 1 : i];
      if (w_disp && (CNT_W'(i) == w_cnt_after))
        w_next[i] = w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_count <= '0;
    end else begin
      r_count <= w_next_count;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= w_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_data  <= '0;
      r_cdb_tag   <= '0;
    end else if (w_flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cdb_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state    <= S_BUSY;
            r_cnt      <= LAT_W'(LATENCY);
            r_cdb_data <= w_quot;
            r_cdb_tag  <= w_sel.rdtag;
          end
        end
        S_BUSY: begin
          if (r_cnt == LAT_W'(1)) begin
            r_state     <= S_DONE;
            r_cnt       <= '0;
            r_cdb_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - LAT_W'(1);
          end
        end
        S_DONE: begin
          if (cdb_grant) begin
            r_cdb_valid <= 1'b0;
            if (w_issue) begin
              r_state    <= S_BUSY;
              r_cnt      <= LAT_W'(LATENCY);
              r_cdb_data <= w_quot;
              r_cdb_tag  <= w_sel.rdtag;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cdb_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_queue.sv
// Testbench for div_issue_queue: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// queue-based behavioural model.
module tb_div_issue_queue;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 8;
  localparam int TAG_W   = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             dispatch_en = 1'b0;
  logic [TAG_W-1:0] dispatch_rdtag = '0;
  logic [31:0]      dispatch_rsdata = '0;
  logic [31:0]      dispatch_rtdata = '0;
  logic [TAG_W-1:0] dispatch_rstag = '0;
  logic [TAG_W-1:0] dispatch_rttag = '0;
  logic             dispatch_rsvalid = 1'b0;
  logic             dispatch_rtvalid = 1'b0;
  logic             dispatch_ready;
  logic [31:0]      cdbin_data = '0;
  logic [TAG_W-1:0] cdbin_tag = '0;
  logic             cdbin_valid = 1'b0;
  logic [31:0]      cdb_data;
  logic [TAG_W-1:0] cdb_tag;
  logic             cdb_valid;
  logic             cdb_grant = 1'b1;
  logic             cdb_branch;
  logic             cdb_branch_taken;
  logic [1:0]       o_dbg_state;

  div_issue_queue #(.DEPTH(DEPTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
`ifdef DIV_ISSUE_QUEUE_FLUSH_EN
    .flush(flush),
`endif
    .dispatch_en(dispatch_en), .dispatch_rdtag(dispatch_rdtag),
    .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
    .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
    .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
    .dispatch_ready(dispatch_ready),
    .cdbin_data(cdbin_data), .cdbin_tag(cdbin_tag), .cdbin_valid(cdbin_valid),
    .cdb_data(cdb_data), .cdb_tag(cdb_tag), .cdb_valid(cdb_valid),
    .cdb_grant(cdb_grant), .cdb_branch(cdb_branch),
    .cdb_branch_taken(cdb_branch_taken), .o_dbg_state(o_dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [TAG_W-1:0] rd;
    logic [31:0]      rs;
    logic [31:0]      rt;
    logic [TAG_W-1:0] rstag;
    logic [TAG_W-1:0] rttag;
    logic             rsv;
    logic             rtv;
  } m_ent_t;

  m_ent_t           mq[$];
  int               m_left = 0;     // cycles of divider work remaining
  bit               m_done = 1'b0;  // result waiting for a grant
  logic [31:0]      m_res = '0;
  logic [TAG_W-1:0] m_tag = '0;
  bit               m_live = 1'b0;
  logic             m_flush;

`ifdef DIV_ISSUE_QUEUE_FLUSH_EN
  assign m_flush = flush;
`else
  assign m_flush = 1'b0;
`endif

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
    return 32'(sa / sb);
  endfunction

  always @(posedge clk) begin : model
    int     pick;
    int     old_size;
    m_ent_t e;
    m_ent_t n;
    if (rst) begin
      mq.delete();
      m_left = 0;
      m_done = 1'b0;
      m_res  = '0;
      m_tag  = '0;
      m_live = 1'b1;
    end else if (m_flush) begin
      mq.delete();
      m_left = 0;
      m_done = 1'b0;
    end else begin
      old_size = mq.size();
      pick = -1;
      if (m_left == 0 && (!m_done || cdb_grant)) begin
        for (int i = 0; i < mq.size(); i++)
          if (pick < 0 && mq[i].rsv && mq[i].rtv) pick = i;
      end
      if (pick >= 0) e = mq[pick];
      for (int i = 0; i < mq.size(); i++) begin
        if (cdbin_valid && !mq[i].rsv && mq[i].rstag == cdbin_tag) begin
          mq[i].rsv = 1'b1; mq[i].rs = cdbin_data;
        end
        if (cdbin_valid && !mq[i].rtv && mq[i].rttag == cdbin_tag) begin
          mq[i].rtv = 1'b1; mq[i].rt = cdbin_data;
        end
      end
      if (pick >= 0) mq.delete(pick);
      if (dispatch_en && old_size < DEPTH) begin
        n.rd = dispatch_rdtag; n.rs = dispatch_rsdata; n.rt = dispatch_rtdata;
        n.rstag = dispatch_rstag; n.rttag = dispatch_rttag;
        n.rsv = dispatch_rsvalid; n.rtv = dispatch_rtvalid;
        if (cdbin_valid && !n.rsv && n.rstag == cdbin_tag) begin n.rsv = 1'b1; n.rs = cdbin_data; end
        if (cdbin_valid && !n.rtv && n.rttag == cdbin_tag) begin n.rtv = 1'b1; n.rt = cdbin_data; end
        mq.push_back(n);
      end
      if (m_done && cdb_grant) m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end
      if (pick >= 0) begin
        m_left = LATENCY;
        m_res  = ref_div(e.rs, e.rt);
        m_tag  = e.rd;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (m_live) begin
      chk("cmp_ready", {31'd0, dispatch_ready}, {31'd0, mq.size() < DEPTH});
      chk("cmp_valid", {31'd0, cdb_valid}, {31'd0, m_done});
      if (m_done) begin
        chk("cmp_data", cdb_data, m_res);
        chk("cmp_tag", {26'd0, cdb_tag}, {26'd0, m_tag});
      end
      chk("cmp_branch", {30'd0, cdb_branch, cdb_branch_taken}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int rd, input int rs, input int rt, input bit rsv,
                       input bit rtv, input int rstag, input int rttag);
    dispatch_en      = 1'b1;
    dispatch_rdtag   = TAG_W'(rd);
    dispatch_rsdata  = 32'(rs);
    dispatch_rtdata  = 32'(rt);
    dispatch_rsvalid = rsv;
    dispatch_rtvalid = rtv;
    dispatch_rstag   = TAG_W'(rstag);
    dispatch_rttag   = TAG_W'(rttag);
  endtask

  task automatic clear_in();
    dispatch_en = 1'b0;
    cdbin_valid = 1'b0;
  endtask

  // Steps until cdb_valid; inputs are cleared after the first edge.
  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!cdb_valid && n < 200) begin
      step();
      n++;
      if (n == 1) clear_in();
    end
    chk({name, "_timeout"}, {31'd0, cdb_valid}, 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] got_d[2];
    logic [31:0] got_t[2];
    int got;
    logic [31:0] hold_d;
    logic [31:0] hold_t;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, cdb_valid}, 32'd0);
    chk("rst_data", cdb_data, 32'd0);
    chk("rst_tag", {26'd0, cdb_tag}, 32'd0);
    chk("rst_ready", {31'd0, dispatch_ready}, 32'd1);
    chk("rst_state", {30'd0, o_dbg_state}, 32'd0);

    // 100/7 tag 5
    cdb_grant = 1'b1;
    drive(5, 100, 7, 1, 1, 0, 0);
    wait_valid("t1", n);
    chk("t1_latency", n, LATENCY + 2);
    chk("t1_data", cdb_data, 32'd14);
    chk("t1_tag", {26'd0, cdb_tag}, 32'd5);
    step();

    // -9/2 then 1/0, in order
    drive(3, -9, 2, 1, 1, 0, 0);
    step();
    drive(4, 1, 0, 1, 1, 0, 0);
    step();
    clear_in();
    got = 0;
    for (int i = 0; i < 100 && got < 2; i++) begin
      step();
      if (cdb_valid) begin
        got_d[got] = cdb_data;
        got_t[got] = {26'd0, cdb_tag};
        got++;
      end
    end
    chk("t2_count", got, 2);
    chk("t2_d0", got_d[0], 32'hFFFF_FFFC);
    chk("t2_t0", got_t[0], 32'd3);
    chk("t2_d1", got_d[1], 32'hFFFF_FFFF);
    chk("t2_t1", got_t[1], 32'd4);
    step();

    // fill with entries waiting on tag 9
    for (int i = 0; i < DEPTH; i++) begin
      drive(20 + i, 0, 2, 0, 1, 9, 0);
      step();
    end
    clear_in();
    chk("t3_full", {31'd0, dispatch_ready}, 32'd0);
    cdbin_valid = 1'b1; cdbin_tag = 6'd9; cdbin_data = 32'd40;
    step();
    clear_in();
    chk("t3_woken_not_issued", {31'd0, dispatch_ready}, 32'd0);
    chk("t3_state_idle", {30'd0, o_dbg_state}, 32'd0);
    step();
    chk("t3_ready_back", {31'd0, dispatch_ready}, 32'd1);
    chk("t3_state_busy", {30'd0, o_dbg_state}, 32'd1);
    repeat (DEPTH * (LATENCY + 3) + 5) step();

    // dispatch bypass: waiting on 12 while 12 broadcasts 50; 50/5
    drive(7, 0, 5, 0, 1, 12, 0);
    cdbin_valid = 1'b1; cdbin_tag = 6'd12; cdbin_data = 32'd50;
    wait_valid("t4", n);
    chk("t4_latency", n, LATENCY + 2);
    chk("t4_data", cdb_data, 32'd10);
    chk("t4_tag", {26'd0, cdb_tag}, 32'd7);
    step();

    // hold grant low in DONE
    cdb_grant = 1'b0;
    drive(1, 100, 7, 1, 1, 0, 0);
    step();
    drive(2, 50, 5, 1, 1, 0, 0);
    wait_valid("t5", n);
    chk("t5_data", cdb_data, 32'd14);
    chk("t5_tag", {26'd0, cdb_tag}, 32'd1);
    hold_d = cdb_data;
    hold_t = {26'd0, cdb_tag};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_valid", {31'd0, cdb_valid}, 32'd1);
      chk("t5_hold_data", cdb_data, hold_d);
      chk("t5_hold_tag", {26'd0, cdb_tag}, hold_t);
      chk("t5_hold_state", {30'd0, o_dbg_state}, 32'd2);
    end
    cdb_grant = 1'b1;
    step();
    chk("t5_reissue_state", {30'd0, o_dbg_state}, 32'd1);
    chk("t5_reissue_valid", {31'd0, cdb_valid}, 32'd0);
    repeat (LATENCY + 5) step();

    // reset during BUSY with a stuck entry queued
    drive(8, 90, 3, 1, 1, 0, 0);
    step();
    drive(9, 0, 3, 0, 1, 30, 0);
    step();
    clear_in();
    repeat (3) step();
    chk("t6_busy", {30'd0, o_dbg_state}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < LATENCY + 6; i++) begin
      step();
      chk("t6_no_cdb", {31'd0, cdb_valid}, 32'd0);
    end
    chk("t6_state", {30'd0, o_dbg_state}, 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(10 + i, 0, 1, 0, 1, 31, 0);
      step();
    end
    clear_in();
    chk("t6_queue_emptied", {31'd0, dispatch_ready}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;

`ifdef DIV_ISSUE_QUEUE_FLUSH_EN
    drive(8, 90, 3, 1, 1, 0, 0);
    step();
    clear_in();
    repeat (3) step();
    flush = 1'b1;
    drive(11, 5, 1, 1, 1, 0, 0);
    step();
    flush = 1'b0;
    clear_in();
    chk("t7_flush_state", {30'd0, o_dbg_state}, 32'd0);
    for (int i = 0; i < LATENCY + 6; i++) begin
      step();
      chk("t7_no_cdb", {31'd0, cdb_valid}, 32'd0);
    end
`endif

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      dispatch_en      = ($urandom_range(0, 2) != 0);
      dispatch_rdtag   = TAG_W'($urandom_range(0, 7));
      dispatch_rsdata  = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: dispatch_rtdata = 32'd0;
        1: dispatch_rtdata = 32'hFFFF_FFFF;
        2: dispatch_rtdata = 32'($urandom_range(1, 20));
        default: dispatch_rtdata = $urandom;
      endcase
      dispatch_rsvalid = ($urandom_range(0, 2) != 0);
      dispatch_rtvalid = ($urandom_range(0, 2) != 0);
      dispatch_rstag   = TAG_W'($urandom_range(0, 7));
      dispatch_rttag   = TAG_W'($urandom_range(0, 7));
      cdbin_valid      = ($urandom_range(0, 2) == 0);
      cdbin_tag        = TAG_W'($urandom_range(0, 7));
      cdbin_data       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      cdb_grant        = ($urandom_range(0, 3) != 0);
      rst              = ($urandom_range(0, 399) == 0);
`ifdef DIV_ISSUE_QUEUE_FLUSH_EN
      flush            = ($urandom_range(0, 299) == 0);
`endif
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
    clear_in();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_issue_queue.md
DIV_ISSUE_QUEUE -- requirements
Module: div_issue_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, number of queue entries (2..16). LATENCY, default 8, divider busy cycles (2..34). TAG_W, default 6, tag width.
REQ-002 Clock: clk  input  1  single clock, all state updates on its rising edge.
REQ-003 Reset: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 dispatch_en  input  1  dispatch request, accepted only when dispatch_ready is 1.
REQ-005 dispatch_rdtag  input  TAG_W  destination tag of the instruction.
REQ-006 dispatch_rsdata / dispatch_rtdata  input  32  operand values, meaningful when the matching valid bit is 1.
REQ-007 dispatch_rstag / dispatch_rttag  input  TAG_W  producer tags, meaningful when the matching valid bit is 0.
REQ-008 dispatch_rsvalid / dispatch_rtvalid  input  1  operand already available.
REQ-009 dispatch_ready  output  1  queue can accept a dispatch this cycle.
REQ-010 cdbin_data  input  32, cdbin_tag  input  TAG_W, cdbin_valid  input  1: snooped common data bus broadcast.
REQ-011 cdb_data  output  32, cdb_tag  output  TAG_W, cdb_valid  output  1: result request to the CDB arbiter.
REQ-012 cdb_grant  input  1  arbiter accepts the result currently presented.
REQ-013 cdb_branch, cdb_branch_taken  output  1 each  SHALL be constant 0.

Function
REQ-014 dispatch_ready SHALL be 1 exactly when fewer than DEPTH entries are valid. It is combinational from the registered occupancy and does not depend on same-cycle issue.
REQ-015 Entries SHALL be kept in age order: index 0 is the oldest. Removing an entry compacts all younger entries down by one in the same cycle.
REQ-016 A dispatch SHALL write into the lowest free index after compaction.
REQ-017 Wakeup: each valid entry with an unavailable operand SHALL capture cdbin_data and set that operand valid when cdbin_valid=1 and cdbin_tag equals the operand's stored tag.
REQ-018 Dispatch bypass: if a dispatched operand is not valid and its tag matches a same-cycle cdbin broadcast, the entry SHALL be written with that operand valid and holding cdbin_data.
REQ-019 Divider states SHALL be IDLE, BUSY and DONE.
REQ-020 IDLE->BUSY: the oldest entry with both operands valid is removed and loaded into the divider. Only one issue per cycle.
REQ-021 An entry SHALL NOT issue in the same cycle it is dispatched or woken. The earliest issue is the next cycle.
REQ-022 BUSY SHALL last exactly LATENCY cycles, counted by a down-counter, then move to DONE.
REQ-023 DONE SHALL drive cdb_valid=1 with a stable cdb_data and cdb_tag until a cycle with cdb_grant=1. In that cycle the divider returns to IDLE and may issue in the same cycle.
REQ-024 cdb_grant while not in DONE SHALL be ignored.
REQ-025 Result SHALL be the signed 32-bit quotient (rs/rt), truncated toward zero.
REQ-026 rt=0 SHALL yield 32'hFFFFFFFF.
REQ-027 0x80000000 / 0xFFFFFFFF SHALL yield 32'h80000000.
REQ-028 cdb_tag SHALL equal the issued entry's rdtag.
REQ-029 A divider result broadcast SHALL wake matching queue entries only through the cdbin_* inputs; there is no internal forwarding.
REQ-030 Dispatch, wakeup, issue and grant in the same cycle SHALL all take effect, with no lost or duplicated entry.

Reset
REQ-031 On rst=1 at a clock edge, all entries SHALL become invalid and the divider SHALL go to IDLE with the counter at 0.
REQ-032 On that same edge, cdb_valid, cdb_data and cdb_tag SHALL be 0, and dispatch_ready SHALL read 1 from the next cycle.
REQ-033 Reset mid-division SHALL discard the operation without producing any CDB output.

Configuration
REQ-034 Macro DIV_ISSUE_QUEUE_FLUSH_EN, when defined, SHALL add the port flush  input  1.
REQ-035 With the macro defined, flush=1 SHALL invalidate all entries and force the divider to IDLE with cdb_valid=0 on the next edge. Same-cycle dispatch is dropped. rst has priority over flush.
REQ-036 Without the macro, the port SHALL be absent and entries are removed only by issue or reset.

Verification
REQ-037 Dispatch rs=100, rt=7, both valid, tag=5; grant held 1 -> cdb_valid=1, cdb_data=14, cdb_tag=5, LATENCY+2 cycles after dispatch.
REQ-038 Dispatch rs=-9, rt=2, tag=3, then rs=1, rt=0, tag=4 -> results 0xFFFFFFFC tag 3, then 0xFFFFFFFF tag 4, in that order.
REQ-039 Fill DEPTH entries with rs waiting on tag 9 -> dispatch_ready=0. Broadcast tag 9 with data 40 -> oldest issues next cycle and dispatch_ready returns to 1.
REQ-040 Dispatch rs waiting on tag 12 while cdbin tag 12 with data 50 is broadcast in the same cycle -> entry issues next cycle with no further broadcast; result 50/rt.
REQ-041 Hold cdb_grant=0 for 5 cycles in DONE -> cdb_valid, data and tag stay stable and a ready entry stays queued. Grant=1 -> a new issue occurs in that same cycle.
REQ-042 Assert rst during BUSY (and flush, if DIV_ISSUE_QUEUE_FLUSH_EN is defined) -> no cdb_valid for the discarded operation, and the queue is empty.
